// File: rtl/spi_cmd_master.sv
// SPI command master, mode 0, MSB first.
// Frames len_i bytes from a valid/ready byte stream under one CSn assertion.
// The LOAD cycle that accepts a byte also serves as the first low cycle of
// bit 7, so a byte takes 16*CLK_DIV cycles with no stall and the first
// rising edge follows CSn by CS_SETUP+CLK_DIV cycles.
module spi_cmd_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] len_i,
    input  logic        abort_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        spi_clk_o,
    output logic        spi_mosi_o,
    output logic        spi_csn_o
);

    // One shared phase counter covers setup, SCLK half-periods, hold and gap.
    localparam int unsigned M_A    = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned M_B    = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int unsigned MAXCNT = (M_A > M_B) ? M_A : M_B;
    localparam int unsigned CW     = (MAXCNT > 1) ? $clog2(MAXCNT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [15:0]   rem_q, rem_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          csn_q, csn_d;
    logic          abort_q, abort_d;

    // True on the final cycle of an n-cycle phase (n of 0 treated as 1).
    function automatic logic cnt_last(input logic [CW-1:0] c, input int unsigned n);
        return (int'(c) + 1) >= int'(n);
    endfunction

    // A byte is only taken when no abort is active, so an abort never eats data.
    assign tx_ready_o = (state_q == S_LOAD) && !abort_i && !abort_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_csn_o  = csn_q;

    // Next-state and datapath update for the framing FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;
        abort_d = abort_q;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                cnt_d   = '0;
                if (start_i) begin
                    if (len_i != 16'd0) begin
                        rem_d   = len_i;
                        csn_d   = 1'b0;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_SETUP: begin
                if (abort_i) abort_d = 1'b1;
                if (cnt_last(cnt_q, CS_SETUP)) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_LOAD: begin
                if (abort_i || abort_q) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (tx_valid_i) begin
                    shreg_d = tx_data_i;
                    mosi_d  = tx_data_i[7];
                    bit_d   = 3'd0;
                    // This cycle already counts as one low cycle of bit 7.
                    cnt_d   = (CLK_DIV > 1) ? CW'(1) : '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (abort_i) abort_d = 1'b1;
                if (cnt_last(cnt_q, CLK_DIV)) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            rem_d = rem_q - 16'd1;
                            if ((rem_q == 16'd1) || abort_q || abort_i) begin
                                state_d = S_HOLD;
                            end else begin
                                state_d = S_LOAD;
                            end
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shreg_d = {shreg_q[6:0], 1'b0};
                            mosi_d  = shreg_q[6];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HOLD: begin
                if (cnt_last(cnt_q, CS_HOLD)) begin
                    cnt_d   = '0;
                    csn_d   = 1'b1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_last(cnt_q, CS_IDLE)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
            abort_q <= abort_d;
        end
    end

endmodule
